car_motion_fsm: RTL and testbench
=================================

# car_motion_fsm

Car motion controller that sits directly upstream of the sprite display stage. It consumes debounced button levels and a once-per-frame tick. It produces the car's horizontal position and the FSM status flags that the renderer reads: move_right, move_left, reset_car_pos, stop. Motion is quantised to one step per frame. Hitting either road boundary latches a collision that only the centre button clears.

## Interface
- X_WIDTH, 10 — width of the car_x position.
- X_MIN, 200 — smallest legal car_x (left road edge).
- X_MAX, 400 — largest legal car_x (right road edge minus car width).
- X_INIT, 300 — car_x after reset or recovery; must satisfy X_MIN ≤ X_INIT ≤ X_MAX.
- STEP, 2 — pixels moved per frame_tick; must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btnc  in  1  debounced centre button (recover/reset car), level.
- btnr  in  1  debounced right button, level.
- btnl  in  1  debounced left button, level.
- frame_tick  in  1  one-clk pulse per video frame.
- car_x  out  X_WIDTH  registered car left-edge x position.
- current_state  out  3  state encoding.
- move_right  out  1  high in RIGHT.
- move_left  out  1  high in LEFT.
- reset_car_pos  out  1  high in RESET.
- stop  out  1  high in COLLIDE.

## Operation
- State encoding: IDLE=0, RIGHT=1, LEFT=2, COLLIDE=3, RESET=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- Status flags are Moore outputs decoded from the state register. car_x is a register.
- Transitions from IDLE, RIGHT or LEFT, in priority order:
  - btnc=1 → RESET.
  - Else a boundary hit this edge → COLLIDE.
  - Else btnr & !btnl → RIGHT.
  - Else btnl & !btnr → LEFT.
  - Else → IDLE (covers both pressed and none pressed).
- COLLIDE: btnl and btnr are ignored. btnc=1 → RESET; otherwise stay.
- RESET: btnc=1 → stay; btnc=0 → IDLE.
- Motion is evaluated only on an edge with frame_tick=1, btnc=0, and state RIGHT or LEFT (current state, not next state).
- RIGHT, computed with an X_WIDTH+1 bit sum:
  - car_x+STEP ≤ X_MAX → car_x += STEP.
  - Otherwise car_x ← X_MAX and it is a boundary hit.
- LEFT:
  - car_x ≥ X_MIN+STEP → car_x −= STEP.
  - Otherwise car_x ← X_MIN and it is a boundary hit.
- Landing exactly on X_MAX or X_MIN is not a hit. The hit occurs on the next tick that tries to pass the boundary; car_x stays clamped.
- In RESET, car_x ← X_INIT on every edge.
- In IDLE and COLLIDE, car_x holds regardless of frame_tick.

## Timing
- rst=1 at an edge sets current_state=IDLE and car_x=X_INIT. All four flags are 0 after that edge. rst overrides every other input, including mid-motion and mid-COLLIDE.
- Button-to-state latency is 1 clk; flags follow the state in the same cycle.
- First movement happens on the first frame_tick edge after the state is RIGHT or LEFT. The press edge itself never moves the car.
- Collision: car_x clamp and the transition to COLLIDE occur on the same edge. stop=1 from that edge on.
- btnc together with frame_tick while moving: no move; the state goes to RESET. car_x=X_INIT one edge later.
- Leaving RESET: IDLE one edge after btnc falls. A held btnr/btnl takes effect one further edge later.
- A frame_tick wider than one cycle moves the car once per high cycle. The upstream stage guarantees single-cycle pulses.

## Test plan
1. Reset: rst=1 for 2 clk, then 0, with no buttons → car_x=300, current_state=0, all flags 0; 5 frame_ticks leave car_x=300.
2. Right move: btnr=1 then 10 frame_ticks → current_state=1, move_right=1, car_x=320. Release btnr, give 5 ticks → current_state=0, car_x stays 320.
3. Left collision:
   - Setup: from car_x=300, hold btnl for 51 ticks.
   - After tick 50: car_x=200, state=2.
   - Tick 51: state=3, stop=1, car_x=200.
   - Release btnl, then 10 ticks and btnr pulses: state stays 3, car_x=200.
4. Recovery: in COLLIDE, btnc=1 for 5 clk → state=4, reset_car_pos=1, car_x=300 one edge after entry. btnc=0 → state=0 next edge.
5. Conflicts:
   - btnl=btnr=1 with ticks → state=0, car_x unchanged.
   - btnr=1 and btnc=1 coincident with frame_tick → state=4, no step applied.
6. Right boundary and mid-motion reset:
   - Case A: hold btnr from 300; tick 50 gives car_x=400 with state 1. Tick 51 gives state 3, car_x=400.
   - Case B: separately, assert rst mid-RIGHT at car_x=310 → state=0, car_x=300 next edge.

Source files
------------

// File: rtl/car_motion_fsm.sv
// Car motion controller: turns debounced button levels and a per-frame tick into
// a clamped horizontal car position plus Moore status flags for the renderer.
module car_motion_fsm #(
  parameter int X_WIDTH = 10,
  parameter int X_MIN   = 200,
  parameter int X_MAX   = 400,
  parameter int X_INIT  = 300,
  parameter int STEP    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btnc,
  input  logic               btnr,
  input  logic               btnl,
  input  logic               frame_tick,
  output logic [X_WIDTH-1:0] car_x,
  output logic [2:0]         current_state,
  output logic               move_right,
  output logic               move_left,
  output logic               reset_car_pos,
  output logic               stop
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RIGHT   = 3'd1,
    LEFT    = 3'd2,
    COLLIDE = 3'd3,
    RESET   = 3'd4
  } state_t;

  localparam logic [X_WIDTH:0]   MAX_W    = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0]   LEFT_LIM = (X_WIDTH+1)'(X_MIN + STEP);
  localparam logic [X_WIDTH:0]   STEP_W   = (X_WIDTH+1)'(STEP);
  localparam logic [X_WIDTH-1:0] STEP_X   = X_WIDTH'(STEP);
  localparam logic [X_WIDTH-1:0] MAX_X    = X_WIDTH'(X_MAX);
  localparam logic [X_WIDTH-1:0] MIN_X    = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0] INIT_X   = X_WIDTH'(X_INIT);

  state_t             state, state_next;
  logic [X_WIDTH-1:0] x_next;
  logic [X_WIDTH:0]   sum_r;
  logic [X_WIDTH:0]   x_ext;
  logic               move_en;
  logic               hit;

  // One extra bit on the right-hand sum so an overflow can never wrap past X_MAX.
  assign sum_r   = {1'b0, car_x} + STEP_W;
  assign x_ext   = {1'b0, car_x};
  assign move_en = frame_tick && !btnc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      car_x <= INIT_X;
    end else begin
      state <= state_next;
      car_x <= x_next;
    end
  end

  always_comb begin
    x_next     = car_x;
    hit        = 1'b0;
    state_next = state;

    case (state)
      RIGHT: begin
        if (move_en) begin
          if (sum_r > MAX_W) begin
            x_next = MAX_X;
            hit    = 1'b1;
          end else begin
            x_next = sum_r[X_WIDTH-1:0];
          end
        end
      end
      LEFT: begin
        if (move_en) begin
          if (x_ext < LEFT_LIM) begin
            x_next = MIN_X;
            hit    = 1'b1;
          end else begin
            x_next = car_x - STEP_X;
          end
        end
      end
      RESET:   x_next = INIT_X;
      default: x_next = car_x;
    endcase

    // Centre button outranks a boundary hit, which outranks direction buttons.
    case (state)
      IDLE, RIGHT, LEFT: begin
        if (btnc)               state_next = RESET;
        else if (hit)           state_next = COLLIDE;
        else if (btnr && !btnl) state_next = RIGHT;
        else if (btnl && !btnr) state_next = LEFT;
        else                    state_next = IDLE;
      end
      COLLIDE: state_next = btnc ? RESET : COLLIDE;
      RESET:   state_next = btnc ? RESET : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign current_state = state;
  assign move_right    = (state == RIGHT);
  assign move_left     = (state == LEFT);
  assign reset_car_pos = (state == RESET);
  assign stop          = (state == COLLIDE);

endmodule

// File: tb/tb_car_motion_fsm.sv
// Bench for car_motion_fsm: directed scenarios plus random button/tick traffic,
// all compared against a rule-level model of position and mode.
module tb_car_motion_fsm;

  localparam int X_MIN  = 200;
  localparam int X_MAX  = 400;
  localparam int X_INIT = 300;
  localparam int STEP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnc = 1'b0, btnr = 1'b0, btnl = 1'b0, frame_tick = 1'b0;
  logic [9:0] car_x;
  logic [2:0] current_state;
  logic       move_right, move_left, reset_car_pos, stop;

  int checks = 0;
  int errors = 0;

  // Model: mode as a name-like code and position as a plain integer.
  int m_mode = 0;
  int m_x    = X_INIT;

  car_motion_fsm dut (
    .clk(clk), .rst(rst), .btnc(btnc), .btnr(btnr), .btnl(btnl),
    .frame_tick(frame_tick), .car_x(car_x), .current_state(current_state),
    .move_right(move_right), .move_left(move_left),
    .reset_car_pos(reset_car_pos), .stop(stop)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_status();
    return {3'(m_mode), m_mode == 1, m_mode == 2, m_mode == 4, m_mode == 3};
  endfunction

  function automatic logic [6:0] dut_status();
    return {current_state, move_right, move_left, reset_car_pos, stop};
  endfunction

  // Drive one edge's inputs, let the edge happen, advance the model, settle.
  task automatic cycle(input bit r, input bit c, input bit br, input bit bl, input bit t);
    bit crash;
    rst = r; btnc = c; btnr = br; btnl = bl; frame_tick = t;
    @(posedge clk);
    crash = 1'b0;
    if (r) begin
      m_mode = 0;
      m_x    = X_INIT;
    end else begin
      if (t && !c && m_mode == 1) begin
        if (m_x + STEP <= X_MAX) m_x = m_x + STEP;
        else begin m_x = X_MAX; crash = 1'b1; end
      end else if (t && !c && m_mode == 2) begin
        if (m_x - STEP >= X_MIN) m_x = m_x - STEP;
        else begin m_x = X_MIN; crash = 1'b1; end
      end else if (m_mode == 4) begin
        m_x = X_INIT;
      end
      if (m_mode == 3)      m_mode = c ? 4 : 3;
      else if (m_mode == 4) m_mode = c ? 4 : 0;
      else if (c)           m_mode = 4;
      else if (crash)       m_mode = 3;
      else if (br && !bl)   m_mode = 1;
      else if (bl && !br)   m_mode = 2;
      else                  m_mode = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_status() !== 7'b000_0000 || car_x !== 10'd300) begin
      errors++;
      $display("[TB] FAIL reset_state: status=%b x=%0d required status=0000000 x=300", dut_status(), car_x);
    end
    for (int i = 0; i < 5; i++) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0); end
    checks++;
    if (car_x !== 10'(m_x) || car_x !== 10'd300) begin
      errors++;
      $display("[TB] FAIL reset_idle_ticks: x=%0d required 300", car_x);
    end
  endtask

  task automatic test_right_move();
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (dut_status() !== exp_status() || car_x !== 10'd300) begin
      errors++;
      $display("[TB] FAIL right_press: status=%b x=%0d required status=%b x=300", dut_status(), car_x, exp_status());
    end
    for (int i = 0; i < 10; i++) begin cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 0); end
    checks++;
    if (current_state !== 3'd1 || move_right !== 1'b1 || car_x !== 10'd320 || car_x !== 10'(m_x)) begin
      errors++;
      $display("[TB] FAIL right_10_ticks: state=%0d mr=%b x=%0d required state=1 mr=1 x=320", current_state, move_right, car_x);
    end
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0); end
    checks++;
    if (current_state !== 3'd0 || car_x !== 10'd320 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL right_release: state=%0d x=%0d required state=0 x=320", current_state, car_x);
    end
  endtask

  task automatic test_left_collision();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 50; i++) begin cycle(0, 0, 0, 1, 1); cycle(0, 0, 0, 1, 0); end
    checks++;
    if (current_state !== 3'd2 || car_x !== 10'd200 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL left_tick50: state=%0d x=%0d required state=2 x=200", current_state, car_x);
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (current_state !== 3'd3 || stop !== 1'b1 || car_x !== 10'd200 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL left_hit: state=%0d stop=%b x=%0d required state=3 stop=1 x=200", current_state, stop, car_x);
    end
    for (int i = 0; i < 10; i++) begin cycle(0, 0, i % 2, 0, 1); cycle(0, 0, 1, 0, 0); end
    checks++;
    if (current_state !== 3'd3 || car_x !== 10'd200 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL collide_hold: state=%0d x=%0d required state=3 x=200", current_state, car_x);
    end
  endtask

  task automatic test_recovery();
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (current_state !== 3'd4 || reset_car_pos !== 1'b1 || car_x !== 10'd200) begin
      errors++;
      $display("[TB] FAIL recover_entry: state=%0d rcp=%b x=%0d required state=4 rcp=1 x=200", current_state, reset_car_pos, car_x);
    end
    cycle(0, 1, 0, 0, 1);
    checks++;
    if (car_x !== 10'd300 || current_state !== 3'd4) begin
      errors++;
      $display("[TB] FAIL recover_x: state=%0d x=%0d required state=4 x=300", current_state, car_x);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (current_state !== 3'd0 || car_x !== 10'd300 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL recover_exit: state=%0d x=%0d required state=0 x=300", current_state, car_x);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (current_state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL recover_held_right: state=%0d required 1", current_state);
    end
  endtask

  task automatic test_conflicts();
    int x0;
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 1, 1, 1); cycle(0, 0, 1, 1, 0); end
    x0 = int'(car_x);
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 1, 1, 1); cycle(0, 0, 1, 1, 0); end
    checks++;
    if (current_state !== 3'd0 || int'(car_x) != x0 || car_x !== 10'(m_x)) begin
      errors++;
      $display("[TB] FAIL both_dirs: state=%0d x=%0d required state=0 x=%0d", current_state, car_x, m_x);
    end
    cycle(0, 0, 1, 0, 0);
    x0 = int'(car_x);
    cycle(0, 1, 1, 0, 1);
    checks++;
    if (current_state !== 3'd4 || int'(car_x) != x0 || dut_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL btnc_with_tick: state=%0d x=%0d required state=4 x=%0d", current_state, car_x, x0);
    end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_right_boundary();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) begin cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 0); end
    checks++;
    if (current_state !== 3'd1 || car_x !== 10'd400 || car_x !== 10'(m_x)) begin
      errors++;
      $display("[TB] FAIL right_tick50: state=%0d x=%0d required state=1 x=400", current_state, car_x);
    end
    cycle(0, 0, 1, 0, 1);
    checks++;
    if (current_state !== 3'd3 || car_x !== 10'd400 || stop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL right_hit: state=%0d x=%0d required state=3 x=400", current_state, car_x);
    end
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 0); end
    checks++;
    if (car_x !== 10'd310 || current_state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL pre_rst_310: state=%0d x=%0d required state=1 x=310", current_state, car_x);
    end
    cycle(1, 0, 1, 0, 1);
    checks++;
    if (current_state !== 3'd0 || car_x !== 10'd300 || dut_status() !== 7'b000_0000) begin
      errors++;
      $display("[TB] FAIL mid_motion_rst: state=%0d x=%0d required state=0 x=300", current_state, car_x);
    end
  endtask

  task automatic test_random();
    bit r, c, br, bl, t;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 39) == 0);
      br = ($urandom_range(0, 2) != 0);
      bl = ($urandom_range(0, 2) == 0);
      t  = ($urandom_range(0, 1) == 0);
      cycle(r, c, br, bl, t);
      checks++;
      if (dut_status() !== exp_status() || car_x !== 10'(m_x)) begin
        errors++;
        $display("[TB] FAIL random_step%0d: status=%b x=%0d required status=%b x=%0d", i, dut_status(), car_x, exp_status(), m_x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_move();
    test_left_collision();
    test_recovery();
    test_conflicts();
    test_right_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
